// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-256 key-schedule types and constants.
//   AES256_NK / AES256_NR / AES256_NUM_WORDS : schedule geometry
//   word_t, round_key_t                      : 32-bit word and 128-bit round key
//   key_state_e                              : key-expansion sequencer states
//   rcon_byte()                              : round constant for rcon index 1..7
package aes_pkg;

    localparam int unsigned AES256_NK        = 8;
    localparam int unsigned AES256_NR        = 14;
    localparam int unsigned AES256_NUM_WORDS = 60;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] round_key_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        FIN
    } key_state_e;

    // AES-256 only ever needs rcon[1..7].
    function automatic logic [7:0] rcon_byte(input logic [2:0] r);
        logic [7:0] c;
        case (r)
            3'd1:    c = 8'h01;
            3'd2:    c = 8'h02;
            3'd3:    c = 8'h04;
            3'd4:    c = 8'h08;
            3'd5:    c = 8'h10;
            3'd6:    c = 8'h20;
            3'd7:    c = 8'h40;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/current_word_gen_256.sv
// current_word_gen_256: combinational AES-256 key-schedule word generator.
// Produces w[i] from w[i-1] and w[i-8].
//   i                : word index being produced (8..59)
//   prev_word        : w[i-1]
//   prev_period_word : w[i-8]
//   current_word     : w[i]
module current_word_gen_256
    import aes_pkg::*;
(
    input  logic [5:0] i,
    input  word_t      prev_word,
    input  word_t      prev_period_word,
    output word_t      current_word
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    word_t rot_word;
    word_t temp;

    always_comb begin
        rot_word = {prev_word[23:0], prev_word[31:24]};
        temp     = prev_word;
        if (i[2:0] == 3'd0) begin
            temp = sub_word(rot_word) ^ {rcon_byte(i[5:3]), 24'h000000};
        end else if (i[2:0] == 3'd4) begin
            // Extra SubWord half-way through each 8-word period is AES-256 specific.
            temp = sub_word(prev_word);
        end
        current_word = prev_period_word ^ temp;
    end

endmodule

// File: rtl/key_expansion_ctrl_256.sv
// key_expansion_ctrl_256: AES-256 key-expansion sequencer and round-key store.
// Loads a 256-bit key, generates w[8]..w[59] one word per cycle, then serves
// the 15 round keys through a combinational read port.
//   clk, resetn   : clock, synchronous active-low reset
//   start, key    : expansion request and cipher key (w[0] in key[255:224])
//   abort         : (KEY_ABORT_EN only) cancel expansion and zeroise the store
//   busy, done    : expansion in progress, one-cycle completion pulse
//   key_valid     : store holds a complete schedule
//   rk_idx, rk    : round-key index 0..14 and round key (w[4r] in rk[127:96])
// Build option: define KEY_ABORT_EN to add the abort input and store zeroisation.
module key_expansion_ctrl_256
    import aes_pkg::*;
#(
    parameter int unsigned NK        = 8,
    parameter int unsigned NUM_WORDS = 60
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [255:0] key,
`ifdef KEY_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    input  logic [3:0]   rk_idx,
    output round_key_t   rk
);

    if (NK != AES256_NK || NUM_WORDS != AES256_NUM_WORDS) begin : g_bad_cfg
        $error("key_expansion_ctrl_256 supports only NK=8, NUM_WORDS=60");
    end

    key_state_e   state_q, state_d;
    logic [5:0]   i_q, i_d;
    logic         key_valid_q, key_valid_d;
    logic [255:0] key_hold_q;
    word_t        store_q [NUM_WORDS];

    logic         hold_we;
    logic         load_we;
    logic         exp_we;

    logic [5:0]   prev_idx;
    logic [5:0]   period_idx;
    word_t        prev_word;
    word_t        prev_period_word;
    word_t        current_word;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        key_valid_d = key_valid_q;
        hold_we     = 1'b0;
        load_we     = 1'b0;
        exp_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    hold_we     = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                load_we = 1'b1;
                i_d     = 6'(NK);
                state_d = EXPAND;
            end
            EXPAND: begin
                exp_we = 1'b1;
                if (i_q == 6'(NUM_WORDS - 1)) begin
                    i_d     = 6'd0;
                    state_d = FIN;
                end else begin
                    i_d = i_q + 6'd1;
                end
            end
            FIN: begin
                key_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            i_q         <= 6'd0;
            key_valid_q <= 1'b0;
`ifdef KEY_ABORT_EN
        end else if (abort) begin
            state_q     <= IDLE;
            i_q         <= 6'd0;
            key_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            key_valid_q <= key_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Key holding register and word store
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
`ifdef KEY_ABORT_EN
        if (!resetn || abort) begin
            key_hold_q <= '0;
            for (int k = 0; k < int'(NUM_WORDS); k++) begin
                store_q[k] <= '0;
            end
        end else
`endif
        begin
            if (hold_we) begin
                key_hold_q <= key;
            end
            if (load_we) begin
                for (int k = 0; k < int'(NK); k++) begin
                    store_q[k] <= key_hold_q[32*(int'(NK)-1-k) +: 32];
                end
            end else if (exp_we) begin
                store_q[i_q] <= current_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word generator, fed by direct store indexing
    // ------------------------------------------------------------------
    always_comb begin
        // Guard keeps the indices in range while i is parked at 0 outside EXPAND.
        if (i_q >= 6'(NK)) begin
            prev_idx   = i_q - 6'd1;
            period_idx = i_q - 6'(NK);
        end else begin
            prev_idx   = 6'd0;
            period_idx = 6'd0;
        end
        prev_word        = store_q[prev_idx];
        prev_period_word = store_q[period_idx];
    end

    current_word_gen_256 u_word_gen (
        .i                (i_q),
        .prev_word        (prev_word),
        .prev_period_word (prev_period_word),
        .current_word     (current_word)
    );

    // ------------------------------------------------------------------
    // Outputs and round-key read port
    // ------------------------------------------------------------------
    logic       rk_ok;
    logic [5:0] rk_base;

    always_comb begin
        rk_ok   = key_valid_q && (rk_idx <= 4'(AES256_NR));
        rk_base = rk_ok ? {rk_idx, 2'b00} : 6'd0;
        rk      = '0;
        if (rk_ok) begin
            rk = {store_q[rk_base], store_q[rk_base + 6'd1],
                  store_q[rk_base + 6'd2], store_q[rk_base + 6'd3]};
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_key_expansion_ctrl_256.sv
// tb_key_expansion_ctrl_256: directed self-checking bench for key_expansion_ctrl_256.
// Build with KEY_ABORT_EN defined to include the abort scenario.
module tb_key_expansion_ctrl_256;

    localparam logic [255:0] KEY_A3 =
        256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    localparam logic [255:0] KEY_ZERO = 256'h0;
    localparam logic [127:0] A3_RK0  = 128'h603deb10_15ca71be_2b73aef0_857d7781;
    localparam logic [127:0] A3_RK1  = 128'h1f352c07_3b6108d7_2d9810a3_0914dff4;
    localparam logic [127:0] A3_RK2  = 128'h9ba35411_8e6925af_a51a8b5f_2067fcde;
    localparam logic [127:0] A3_RK14 = 128'hfe4890d1_e6188d0b_046df344_706c631e;
    localparam logic [127:0] Z_RK2   = 128'h62636363_62636363_62636363_62636363;
    localparam logic [127:0] Z_RK14  = 128'h10f80a17_53bf729c_45c979e7_cb706385;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [255:0] key;
`ifdef KEY_ABORT_EN
    logic         abort;
`endif
    logic         busy;
    logic         done;
    logic         key_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    key_expansion_ctrl_256 dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .key       (key),
`ifdef KEY_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .rk_idx    (rk_idx),
        .rk        (rk)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; raises start for the current cycle (cycle T). Returns at the
    // negedge of the done cycle, or after the cycle budget with done_cyc = -1.
    task automatic run_expansion(input logic [255:0] k, input int inject_at,
                                 input logic [255:0] inject_key,
                                 output int done_cyc, output int kv_seen);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start    = 1'b0;
        key      = ~k;
        done_cyc = -1;
        kv_seen  = 0;
        for (int n = 1; n <= 80; n++) begin
            if (done) begin
                done_cyc = n;
                break;
            end
            if (key_valid) kv_seen++;
            if (n == inject_at) begin
                start = 1'b1;
                key   = inject_key;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
        rk_idx = idx;
        #1;
        v = rk;
    endtask

    task automatic test_reset;
        logic [127:0] v;
        resetn = 1'b0;
        start  = 1'b0;
        key    = '0;
        rk_idx = 4'd0;
`ifdef KEY_ABORT_EN
        abort  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL reset_done: got %b expected 0", done);
        end
        n_cmp++;
        if (key_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_key_valid: got %b expected 0", key_valid);
        end
        for (int idx = 0; idx < 16; idx++) begin
            read_rk(4'(idx), v);
            n_cmp++;
            if (v !== 128'h0) begin
                n_bad++; $display("FAIL reset_rk[%0d]: got %h expected 0", idx, v);
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips_a3;
        int dc, kv;
        logic [127:0] v;
        run_expansion(KEY_A3, 0, KEY_ZERO, dc, kv);
        n_cmp++;
        if (dc !== 54) begin
            n_bad++; $display("FAIL a3_done_cycle: got %0d expected 54", dc);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL a3_done_pulse_width: got %b expected 0", done);
        end
        n_cmp++;
        if (key_valid !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL a3_key_valid_busy: got %b%b expected 10", key_valid, busy);
        end
        read_rk(4'd0, v);
        n_cmp++;
        if (v !== A3_RK0) begin
            n_bad++; $display("FAIL a3_rk0: got %h expected %h", v, A3_RK0);
        end
        read_rk(4'd1, v);
        n_cmp++;
        if (v !== A3_RK1) begin
            n_bad++; $display("FAIL a3_rk1: got %h expected %h", v, A3_RK1);
        end
        read_rk(4'd2, v);
        n_cmp++;
        if (v[127:96] !== 32'h9ba35411) begin
            n_bad++; $display("FAIL a3_w8: got %h expected 9ba35411", v[127:96]);
        end
        n_cmp++;
        if (v !== A3_RK2) begin
            n_bad++; $display("FAIL a3_rk2: got %h expected %h", v, A3_RK2);
        end
        read_rk(4'd14, v);
        n_cmp++;
        if (v !== A3_RK14) begin
            n_bad++; $display("FAIL a3_rk14: got %h expected %h", v, A3_RK14);
        end
    endtask

    task automatic test_start_ignored;
        int dc, kv;
        logic [127:0] v;
        @(negedge clk);
        run_expansion(KEY_A3, 10, KEY_ZERO, dc, kv);
        n_cmp++;
        if (dc !== 54) begin
            n_bad++; $display("FAIL ignored_done_cycle: got %0d expected 54", dc);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL ignored_no_rerun: got busy=%b expected 0", busy);
        end
        read_rk(4'd0, v);
        n_cmp++;
        if (v !== A3_RK0) begin
            n_bad++; $display("FAIL ignored_rk0: got %h expected %h", v, A3_RK0);
        end
        read_rk(4'd14, v);
        n_cmp++;
        if (v !== A3_RK14) begin
            n_bad++; $display("FAIL ignored_rk14: got %h expected %h", v, A3_RK14);
        end
    endtask

    task automatic test_back_to_back;
        int dc, kv;
        logic [127:0] v;
        @(negedge clk);
        run_expansion(KEY_A3, 0, KEY_ZERO, dc, kv);
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_first_valid: got %b expected 1", key_valid);
        end
        run_expansion(KEY_ZERO, 0, KEY_ZERO, dc, kv);
        n_cmp++;
        if (dc !== 54) begin
            n_bad++; $display("FAIL b2b_done_cycle: got %0d expected 54", dc);
        end
        n_cmp++;
        if (kv !== 0) begin
            n_bad++; $display("FAIL b2b_valid_during_run: got %0d cycles expected 0", kv);
        end
        @(negedge clk);
        read_rk(4'd2, v);
        n_cmp++;
        if (v !== Z_RK2) begin
            n_bad++; $display("FAIL b2b_zero_rk2: got %h expected %h", v, Z_RK2);
        end
        read_rk(4'd14, v);
        n_cmp++;
        if (v !== Z_RK14) begin
            n_bad++; $display("FAIL b2b_zero_rk14: got %h expected %h", v, Z_RK14);
        end
        read_rk(4'd15, v);
        n_cmp++;
        if (v !== 128'h0) begin
            n_bad++; $display("FAIL b2b_rk15: got %h expected 0", v);
        end
    endtask

    task automatic test_reset_mid;
        int dc, kv, seen;
        logic [127:0] v;
        @(negedge clk);
        start = 1'b1;
        key   = KEY_A3;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_busy_before: got %b expected 1", busy);
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || key_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_idle: got busy=%b key_valid=%b expected 0 0", busy, key_valid);
        end
        seen = 0;
        for (int n = 0; n < 60; n++) begin
            if (done) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", seen);
        end
        run_expansion(KEY_A3, 0, KEY_ZERO, dc, kv);
        n_cmp++;
        if (dc !== 54) begin
            n_bad++; $display("FAIL rstmid_rerun_done: got %0d expected 54", dc);
        end
        @(negedge clk);
        read_rk(4'd14, v);
        n_cmp++;
        if (v !== A3_RK14) begin
            n_bad++; $display("FAIL rstmid_rerun_rk14: got %h expected %h", v, A3_RK14);
        end
    endtask

`ifdef KEY_ABORT_EN
    task automatic test_abort;
        int dc, kv, seen, nz;
        logic [127:0] v;
        @(negedge clk);
        start = 1'b1;
        key   = KEY_A3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || key_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: got busy=%b key_valid=%b expected 0 0", busy, key_valid);
        end
        seen = 0;
        for (int n = 0; n < 60; n++) begin
            if (done) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen);
        end
        nz = 0;
        for (int idx = 0; idx < 16; idx++) begin
            read_rk(4'(idx), v);
            if (v !== 128'h0) nz++;
        end
        n_cmp++;
        if (nz !== 0) begin
            n_bad++; $display("FAIL abort_rk_zero: got %0d nonzero keys expected 0", nz);
        end
        @(negedge clk);
        run_expansion(KEY_A3, 0, KEY_ZERO, dc, kv);
        n_cmp++;
        if (dc !== 54) begin
            n_bad++; $display("FAIL abort_rerun_done: got %0d expected 54", dc);
        end
        @(negedge clk);
        read_rk(4'd0, v);
        n_cmp++;
        if (v !== A3_RK0) begin
            n_bad++; $display("FAIL abort_rerun_rk0: got %h expected %h", v, A3_RK0);
        end
        read_rk(4'd14, v);
        n_cmp++;
        if (v !== A3_RK14) begin
            n_bad++; $display("FAIL abort_rerun_rk14: got %h expected %h", v, A3_RK14);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fips_a3();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
`ifdef KEY_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
